parallel_serializer: RTL and testbench
======================================

Name: parallel_serializer

Overview:
- Consumer end of the write_in/write_ready -> write_out/next_ready stream handshake used by the buffering stages.
- Accepts one WIDTH-bit word from an upstream stage, such as a buffer's write_out/data_out.
- Emits the word downstream as BEATS = WIDTH/OUT_WIDTH narrower slices over the same handshake.
- Used ahead of byte-wide sinks (UART TX, memory byte lanes).

Parameters:
- WIDTH, 16, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output slice width.
- MSB_FIRST, 1, 1 = most-significant slice first; 0 = least-significant slice first.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  input word; sampled when write_in & write_ready.
- write_in  input  1  upstream valid.
- write_ready  output  1  upstream ready; combinational.
- data_out  output  OUT_WIDTH  current slice; registered.
- write_out  output  1  downstream valid; registered.
- last_out  output  1  high with the final slice of a word; registered.
- next_ready  input  1  downstream ready.

Behaviour:
- Reset (reset_n low, asynchronous): write_out=0, last_out=0, data_out=0, shift register=0, beat counter=0, state=IDLE. Reset mid-word discards the remaining slices; nothing is replayed after reset is released.
- BEATS = WIDTH/OUT_WIDTH, with BEATS >= 2. The beat counter is clog2(BEATS) bits wide.
- Combinational ready: write_ready = ~write_out | (last_out & next_ready).
- Transfer rules:
  - Input transfer occurs on a clock edge where write_in & write_ready.
  - Output transfer occurs on a clock edge where write_out & next_ready.
- States:
  - IDLE: write_out=0.
  - SHIFT: write_out=1.
- IDLE, input transfer:
  - Latch data_in into the shift register.
  - Next cycle: data_out = first slice, write_out=1, last_out=0, counter=0.
  - Go to SHIFT. Latency from accept to first slice valid is 1 cycle.
- SHIFT, output transfer with counter < BEATS-1:
  - Present the next slice and increment the counter.
  - last_out <= (counter == BEATS-2).
- SHIFT, output transfer with counter == BEATS-1 (the last slice is consumed):
  - If write_in is also high: load the new word; its first slice is valid the next cycle with no bubble; stay in SHIFT.
  - Otherwise: write_out<=0, last_out<=0, data_out<=0; go to IDLE.
- Stall: while write_out & ~next_ready, data_out, last_out and the counter hold stable; write_ready=0.
- Slice order:
  - MSB_FIRST=1: slice k = data[WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH].
  - MSB_FIRST=0: slice k = data[k*OUT_WIDTH +: OUT_WIDTH].
- write_in while not ready: ignored. Upstream must hold data_in; nothing is sampled.
- Throughput: sustained one word per BEATS cycles with next_ready held high.
- data_out is 0 whenever write_out=0.

Test Plan:
- Reset then idle: reset_n=0 -> write_out=0, last_out=0, data_out=0, write_ready=1. Release reset_n with write_in=0 -> outputs unchanged.
- Single word, WIDTH=16, OUT_WIDTH=8, MSB_FIRST=1, next_ready=1: accept 0xA55A.
  - Cycle+1: data_out=0xA5, last_out=0.
  - Cycle+2: data_out=0x5A, last_out=1.
  - Cycle+3: write_out=0.
  - write_ready=0 during cycle+1.
- Back-to-back, write_in held high with 0x1234 then 0xBEEF, next_ready=1:
  - Output stream 0x12,0x34,0xBE,0xEF on consecutive cycles with no gap.
  - write_ready pulses high only on the 0x34 cycle.
- Downstream stall: hold next_ready=0 for 3 cycles while 0x12 is presented -> data_out=0x12, write_out=1 and write_ready=0 all stable. Releasing next_ready resumes with 0x34.
- Parameter variant WIDTH=32, OUT_WIDTH=8, MSB_FIRST=0, input 0xDDCCBBAA -> output 0xAA,0xBB,0xCC,0xDD, with last_out high only on 0xDD.
- Reset mid-word: assert reset_n=0 after 0x12 is consumed but before 0x34 -> write_out=0 immediately (asynchronous). After release, write_ready=1 and 0x34 is never emitted.

Source files
------------

// File: rtl/parallel_serializer.sv
// ============================================================================
//  Module   : parallel_serializer
//  Brief    : Splits each WIDTH-bit word into WIDTH/OUT_WIDTH slices on a
//             valid/ready stream; next word can load with no bubble.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module parallel_serializer #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 write_in,
  output logic                 write_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 write_out,
  output logic                 last_out,
  input  logic                 next_ready
);

  localparam int BEATS = WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PENULT_BEAT = CNT_W'(BEATS - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   beat;

  // Slice that leaves first, and the word shifted so the next slice is at the head.
  function automatic logic [OUT_WIDTH-1:0] head(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1 -: OUT_WIDTH];
    else           return w[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w << OUT_WIDTH;
    else           return w >> OUT_WIDTH;
  endfunction

  // Ready while idle, or when the final slice is leaving this very cycle.
  assign write_ready = ~write_out | (last_out & next_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      beat      <= '0;
      data_out  <= '0;
      write_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_in) begin
            shreg     <= advance(data_in);
            data_out  <= head(data_in);
            write_out <= 1'b1;
            last_out  <= 1'b0;
            beat      <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (next_ready) begin
            if (beat != LAST_BEAT) begin
              shreg    <= advance(shreg);
              data_out <= head(shreg);
              beat     <= beat + 1'b1;
              last_out <= (beat == PENULT_BEAT);
            end else if (write_in) begin
              shreg     <= advance(data_in);
              data_out  <= head(data_in);
              write_out <= 1'b1;
              last_out  <= 1'b0;
              beat      <= '0;
            end else begin
              shreg     <= '0;
              data_out  <= '0;
              write_out <= 1'b0;
              last_out  <= 1'b0;
              beat      <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parallel_serializer.sv
// ============================================================================
//  Module   : tb_parallel_serializer
//  Brief    : Directed scoreboard bench for two serializer configurations.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_parallel_serializer;

  logic clock;
  logic reset_n;

  // Instance A: 16 -> 8, MSB first
  logic [15:0] a_data_in;
  logic        a_write_in;
  logic        a_write_ready;
  logic [7:0]  a_data_out;
  logic        a_write_out;
  logic        a_last_out;
  logic        a_next_ready;

  // Instance B: 32 -> 8, LSB first
  logic [31:0] b_data_in;
  logic        b_write_in;
  logic        b_write_ready;
  logic [7:0]  b_data_out;
  logic        b_write_out;
  logic        b_last_out;
  logic        b_next_ready;

  int checks = 0;
  int errors = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  parallel_serializer #(.WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .data_in(a_data_in), .write_in(a_write_in),
    .write_ready(a_write_ready), .data_out(a_data_out), .write_out(a_write_out),
    .last_out(a_last_out), .next_ready(a_next_ready)
  );

  parallel_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .data_in(b_data_in), .write_in(b_write_in),
    .write_ready(b_write_ready), .data_out(b_data_out), .write_out(b_write_out),
    .last_out(b_last_out), .next_ready(b_next_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: an output transfer happens at the next rising edge.
  always @(negedge clock) begin
    if (reset_n && a_write_out && a_next_ready) begin
      if (q_a.size() == 0) check("a_unexpected_beat", {23'd0, a_last_out, a_data_out}, 32'h1ff);
      else check("a_beat", {23'd0, a_last_out, a_data_out}, {23'd0, q_a.pop_front()});
    end
    if (reset_n && b_write_out && b_next_ready) begin
      if (q_b.size() == 0) check("b_unexpected_beat", {23'd0, b_last_out, b_data_out}, 32'h1ff);
      else check("b_beat", {23'd0, b_last_out, b_data_out}, {23'd0, q_b.pop_front()});
    end
  end

  initial begin
    logic [31:0] wb;
    reset_n = 1'b1;
    a_data_in = '0; a_write_in = 1'b0; a_next_ready = 1'b1;
    b_data_in = '0; b_write_in = 1'b0; b_next_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_write_out", a_write_out, 0);
    check("rst_last_out", a_last_out, 0);
    check("rst_data_out", a_data_out, 0);
    check("rst_write_ready", a_write_ready, 1);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    check("idle_write_out", a_write_out, 0);
    check("idle_data_out", a_data_out, 0);
    check("idle_write_ready", a_write_ready, 1);

    // Single word
    a_data_in = 16'hA55A; a_write_in = 1'b1;
    q_a.push_back({1'b0, 8'hA5}); q_a.push_back({1'b1, 8'h5A});
    check("single_ready_idle", a_write_ready, 1);
    step();
    a_write_in = 1'b0;
    check("single_c1_valid", a_write_out, 1);
    check("single_c1_data", a_data_out, 8'hA5);
    check("single_c1_last", a_last_out, 0);
    check("single_c1_ready", a_write_ready, 0);
    step();
    check("single_c2_data", a_data_out, 8'h5A);
    check("single_c2_last", a_last_out, 1);
    step();
    check("single_c3_valid", a_write_out, 0);
    check("single_c3_data", a_data_out, 0);

    // Back-to-back words, no bubble
    a_data_in = 16'h1234; a_write_in = 1'b1;
    q_a.push_back({1'b0, 8'h12}); q_a.push_back({1'b1, 8'h34});
    step();
    a_data_in = 16'hBEEF;
    q_a.push_back({1'b0, 8'hBE}); q_a.push_back({1'b1, 8'hEF});
    check("b2b_12_data", a_data_out, 8'h12);
    check("b2b_12_ready", a_write_ready, 0);
    step();
    check("b2b_34_data", a_data_out, 8'h34);
    check("b2b_34_ready", a_write_ready, 1);
    step();
    a_write_in = 1'b0;
    check("b2b_be_valid", a_write_out, 1);
    check("b2b_be_data", a_data_out, 8'hBE);
    check("b2b_be_ready", a_write_ready, 0);
    step();
    check("b2b_ef_data", a_data_out, 8'hEF);
    check("b2b_ef_last", a_last_out, 1);
    step();
    check("b2b_idle", a_write_out, 0);

    // Downstream stall
    a_data_in = 16'h1234; a_write_in = 1'b1;
    q_a.push_back({1'b0, 8'h12}); q_a.push_back({1'b1, 8'h34});
    step();
    a_write_in = 1'b0; a_next_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_data", a_data_out, 8'h12);
      check("stall_valid", a_write_out, 1);
      check("stall_ready", a_write_ready, 0);
      check("stall_last", a_last_out, 0);
      step();
    end
    a_next_ready = 1'b1;
    step();
    check("stall_resume_data", a_data_out, 8'h34);
    check("stall_resume_last", a_last_out, 1);
    step();
    check("stall_idle", a_write_out, 0);

    // 32 -> 8, LSB first
    b_data_in = 32'hDDCCBBAA; b_write_in = 1'b1;
    wb = 32'hDDCCBBAA;
    for (int k = 0; k < 4; k++) q_b.push_back({k == 3, wb[8*k +: 8]});
    step();
    b_write_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lsb_data", b_data_out, {24'd0, wb[8*k +: 8]});
      check("lsb_last", b_last_out, {31'd0, k == 3});
      step();
    end
    check("lsb_idle", b_write_out, 0);

    // Reset mid-word: 0x34 must never appear
    a_data_in = 16'h1234; a_write_in = 1'b1;
    q_a.push_back({1'b0, 8'h12});
    step();
    a_write_in = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", a_write_out, 0);
    check("midrst_data", a_data_out, 0);
    check("midrst_last", a_last_out, 0);
    step();
    reset_n = 1'b1;
    check("midrst_ready", a_write_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_replay", a_write_out, 0);
    end

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
